uart_tx_fsm_ser: RTL



---
 rtl/uart_tx_fsm_ser.sv | 90 +++++++++
 1 files changed

// File: rtl/uart_tx_fsm_ser.sv
// uart_tx_fsm_ser: UART transmitter; start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// Each bit lasts P = prescale (8, 16 or 32; anything else is 8) clock cycles.
module uart_tx_fsm_ser #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE_W = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] p_data,
   input  logic                  data_valid,
   input  logic                  par_en,
   input  logic                  par_typ,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic                  tx_out,
   output logic                  busy,
   output logic                  tx_done
);
   localparam int IW = $clog2(DATA_WIDTH);
   localparam logic [IW-1:0] LAST = IW'(DATA_WIDTH - 1);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t state, state_n;
   logic [PRESCALE_W-1:0] cnt, cnt_n, per, per_n, per_dec;
   logic [IW-1:0] idx, idx_n;
   logic [DATA_WIDTH-1:0] shift, shift_n;
   logic pen, pen_n, pbit, pbit_n, tx_n, wrap;
   assign per_dec = (prescale == PRESCALE_W'(8) || prescale == PRESCALE_W'(16) ||
                     prescale == PRESCALE_W'(32)) ? prescale : PRESCALE_W'(8);
   assign wrap = cnt == per - PRESCALE_W'(1);
   always_comb begin
      state_n = state;
      cnt_n   = wrap ? '0 : cnt + PRESCALE_W'(1);
      idx_n   = idx;
      shift_n = shift;
      per_n   = per;
      pen_n   = pen;
      pbit_n  = pbit;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (data_valid) begin
               state_n = START;
               shift_n = p_data;
               per_n   = per_dec;
               pen_n   = par_en;
               pbit_n  = ^p_data ^ par_typ;
               idx_n   = '0;
            end
         end
         START:  state_n = wrap ? DATA : state;
         DATA: begin
            if (wrap) begin
               shift_n = shift >> 1;
               idx_n   = idx + IW'(1);
               state_n = (idx == LAST) ? (pen ? PARITY : STOP) : DATA;
            end
         end
         PARITY: state_n = wrap ? STOP : state;
         STOP:   state_n = wrap ? IDLE : state;
         default: state_n = IDLE;
      endcase
      // tx_out is registered, so it is driven from the state being entered
      tx_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] :
             state_n == PARITY ? pbit_n : 1'b1;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         idx     <= '0;
         shift   <= '0;
         per     <= '0;
         pen     <= 1'b0;
         pbit    <= 1'b0;
         tx_out  <= 1'b1;
         busy    <= 1'b0;
         tx_done <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         idx     <= idx_n;
         shift   <= shift_n;
         per     <= per_n;
         pen     <= pen_n;
         pbit    <= pbit_n;
         tx_out  <= tx_n;
         busy    <= state_n != IDLE;
         tx_done <= state == STOP && wrap;
      end
   end
endmodule
